// File: rtl/ps2_key_state_decoder_pkg.sv
// Shared constants for the PS/2 key-state decoder: key count, prefix codes,
// parser state encoding and the list of controller/status bytes that carry no key.
package ps2_key_state_decoder_pkg;

    localparam int NUMBEROFKEYBOARDINPUTS = 29;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } parserState_e;

    // Acknowledge, self-test, echo, resend and error bytes are silently dropped.
    function automatic logic isControlCode(input logic [7:0] code);
        return (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
               (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_state_decoder_if.sv
// Byte stream from the PS/2 controller into the decoder, plus key-state/event outputs.
// master = controller/consumer side, slave = decoder.
interface ps2_key_state_decoder_if #(
    parameter int NUM_KEYS = 29
);
    logic [7:0]          recievedData;
    logic                recievedNewData;
    logic                clearAll;
    logic [NUM_KEYS-1:0] keyState;
    logic                keyPressPulse;
    logic                keyReleasePulse;
    logic [4:0]          keyIndex;
    logic                unknownCode;

    modport master (
        output recievedData, recievedNewData, clearAll,
        input  keyState, keyPressPulse, keyReleasePulse, keyIndex, unknownCode
    );

    modport slave (
        input  recievedData, recievedNewData, clearAll,
        output keyState, keyPressPulse, keyReleasePulse, keyIndex, unknownCode
    );
endinterface

// File: rtl/ps2_scancode_to_key.sv
// Combinational set-2 scan code to key index lookup; keyValid is low for
// codes that have no key assigned (including all extended codes).
module ps2_scancode_to_key (
    input  logic [7:0] scanCode,
    output logic [4:0] keyIdx,
    output logic       keyValid
);

    always_comb begin
        keyIdx   = 5'd0;
        keyValid = 1'b1;
        case (scanCode)
            8'h0E: keyIdx = 5'd0;
            8'h16: keyIdx = 5'd1;
            8'h1E: keyIdx = 5'd2;
            8'h26: keyIdx = 5'd3;
            8'h25: keyIdx = 5'd4;
            8'h2E: keyIdx = 5'd5;
            8'h36: keyIdx = 5'd6;
            8'h3D: keyIdx = 5'd7;
            8'h3E: keyIdx = 5'd8;
            8'h46: keyIdx = 5'd9;
            8'h45: keyIdx = 5'd10;
            8'h4E: keyIdx = 5'd11;
            8'h55: keyIdx = 5'd12;
            8'h66: keyIdx = 5'd13;
            8'h0D: keyIdx = 5'd14;
            8'h15: keyIdx = 5'd15;
            8'h1D: keyIdx = 5'd16;
            8'h24: keyIdx = 5'd17;
            8'h2D: keyIdx = 5'd18;
            8'h2C: keyIdx = 5'd19;
            8'h35: keyIdx = 5'd20;
            8'h3C: keyIdx = 5'd21;
            8'h43: keyIdx = 5'd22;
            8'h44: keyIdx = 5'd23;
            8'h4D: keyIdx = 5'd24;
            8'h54: keyIdx = 5'd25;
            8'h5B: keyIdx = 5'd26;
            8'h5D: keyIdx = 5'd27;
            8'h29: keyIdx = 5'd28;
            default: keyValid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_state_decoder.sv
// Parses make / F0 break / E0 extended PS/2 sequences into a held-key vector
// and one-cycle press/release/unknown events with the key index.
module ps2_key_state_decoder
    import ps2_key_state_decoder_pkg::*;
#(
    parameter int NUM_KEYS       = NUMBEROFKEYBOARDINPUTS,
    parameter int PREFIX_TIMEOUT = 2500000,
    parameter int TIMEOUT_BITS   = 22
) (
    input logic                    CLOCK_50,
    input logic                    resetn,
    ps2_key_state_decoder_if.slave bus
);

    localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_LAST = TIMEOUT_BITS'(PREFIX_TIMEOUT - 1);

    parserState_e            state;
    logic [TIMEOUT_BITS-1:0] timeoutCnt;
    logic [NUM_KEYS-1:0]     keyHeld;
    logic                    pressPulse;
    logic                    releasePulse;
    logic                    unknownPulse;
    logic [4:0]              lastIndex;

    logic [7:0] rxByte;
    logic [4:0] mappedIdx;
    logic       mappedValid;

    assign rxByte = bus.recievedData;

    ps2_scancode_to_key u_scancodeMap (
        .scanCode (rxByte),
        .keyIdx   (mappedIdx),
        .keyValid (mappedValid)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            timeoutCnt   <= '0;
            keyHeld      <= '0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            unknownPulse <= 1'b0;
            lastIndex    <= 5'd0;
        end else begin
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            unknownPulse <= 1'b0;

            if (bus.clearAll) begin
                // Clear wins over any byte strobed in the same cycle.
                state      <= IDLE;
                timeoutCnt <= '0;
                keyHeld    <= '0;
            end else if (bus.recievedNewData) begin
                timeoutCnt <= '0;
                case (state)
                    IDLE: begin
                        if (rxByte == PS2_BREAK) begin
                            state <= BRK;
                        end else if (rxByte == PS2_EXT) begin
                            state <= EXT;
                        end else if (mappedValid) begin
                            // Typematic repeats of a held key produce no event.
                            if (!keyHeld[mappedIdx]) begin
                                keyHeld[mappedIdx] <= 1'b1;
                                pressPulse         <= 1'b1;
                                lastIndex          <= mappedIdx;
                            end
                        end else if (!isControlCode(rxByte)) begin
                            unknownPulse <= 1'b1;
                        end
                    end
                    BRK: begin
                        if (rxByte == PS2_BREAK) begin
                            state <= BRK;
                        end else if (rxByte == PS2_EXT) begin
                            state <= EXT;
                        end else begin
                            state <= IDLE;
                            if (mappedValid && keyHeld[mappedIdx]) begin
                                keyHeld[mappedIdx] <= 1'b0;
                                releasePulse       <= 1'b1;
                                lastIndex          <= mappedIdx;
                            end
                        end
                    end
                    EXT: begin
                        state <= (rxByte == PS2_BREAK) ? EXT_BRK : IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                // A stalled prefix is abandoned so a lost byte cannot wedge the parser.
                if (timeoutCnt == TIMEOUT_LAST) begin
                    state      <= IDLE;
                    timeoutCnt <= '0;
                end else begin
                    timeoutCnt <= timeoutCnt + 1'b1;
                end
            end
        end
    end

    assign bus.keyState        = keyHeld;
    assign bus.keyPressPulse   = pressPulse;
    assign bus.keyReleasePulse = releasePulse;
    assign bus.unknownCode     = unknownPulse;
    assign bus.keyIndex        = lastIndex;

endmodule

// File: tb/tb_ps2_key_state_decoder.sv
// Directed bench for ps2_key_state_decoder with hand-computed expected values.
module tb_ps2_key_state_decoder;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ps2_key_state_decoder_if #(.NUM_KEYS(29)) bus ();

    ps2_key_state_decoder #(
        .NUM_KEYS       (29),
        .PREFIX_TIMEOUT (100),
        .TIMEOUT_BITS   (8)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        bus.recievedData    = b;
        bus.recievedNewData = 1'b1;
        @(posedge clk);
        #1;
        bus.recievedNewData = 1'b0;
    endtask

    task automatic checkEvent(input string tag, input logic p, input logic r, input logic u,
                              input logic [4:0] idx, input logic [28:0] ks);
        check({tag, "_press"},   {31'd0, bus.keyPressPulse},   {31'd0, p});
        check({tag, "_release"}, {31'd0, bus.keyReleasePulse}, {31'd0, r});
        check({tag, "_unknown"}, {31'd0, bus.unknownCode},     {31'd0, u});
        check({tag, "_index"},   {27'd0, bus.keyIndex},        {27'd0, idx});
        check({tag, "_state"},   {3'd0, bus.keyState},         {3'd0, ks});
    endtask

    initial begin
        bus.recievedData    = 8'h00;
        bus.recievedNewData = 1'b0;
        bus.clearAll        = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkEvent("reset", 0, 0, 0, 5'd0, 29'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Unmapped code, then key 28
        sendByte(8'h1C); checkEvent("unk1C", 0, 0, 1, 5'd0, 29'h0);
        tick();          checkEvent("unk1C_end", 0, 0, 0, 5'd0, 29'h0);
        sendByte(8'h29); checkEvent("make29", 1, 0, 0, 5'd28, 29'h1000_0000);
        tick();          checkEvent("make29_end", 0, 0, 0, 5'd28, 29'h1000_0000);
        sendByte(8'hF0); checkEvent("brkpfx", 0, 0, 0, 5'd28, 29'h1000_0000);
        sendByte(8'h29); checkEvent("break29", 0, 1, 0, 5'd28, 29'h0);

        // Typematic repeat produces one press only
        sendByte(8'h15); checkEvent("typ1", 1, 0, 0, 5'd15, 29'h0000_8000);
        sendByte(8'h15); checkEvent("typ2", 0, 0, 0, 5'd15, 29'h0000_8000);
        sendByte(8'h15); checkEvent("typ3", 0, 0, 0, 5'd15, 29'h0000_8000);
        sendByte(8'hF0); checkEvent("typF0", 0, 0, 0, 5'd15, 29'h0000_8000);
        sendByte(8'h15); checkEvent("typBrk", 0, 1, 0, 5'd15, 29'h0);
        tick();          checkEvent("typBrk_end", 0, 0, 0, 5'd15, 29'h0);

        // Two keys held, release one
        sendByte(8'h16); checkEvent("hold16", 1, 0, 0, 5'd1, 29'h2);
        sendByte(8'h1E); checkEvent("hold1E", 1, 0, 0, 5'd2, 29'h6);
        sendByte(8'hF0);
        sendByte(8'h16); checkEvent("rel16", 0, 1, 0, 5'd1, 29'h4);

        // Extended break is consumed silently
        sendByte(8'hE0); checkEvent("extE0", 0, 0, 0, 5'd1, 29'h4);
        sendByte(8'hF0); checkEvent("extF0", 0, 0, 0, 5'd1, 29'h4);
        sendByte(8'h75); checkEvent("ext75", 0, 0, 0, 5'd1, 29'h4);
        sendByte(8'h29); checkEvent("postExt29", 1, 0, 0, 5'd28, 29'h1000_0004);

        // Control bytes and unmapped break produce nothing
        sendByte(8'hAA); checkEvent("ctrlAA", 0, 0, 0, 5'd28, 29'h1000_0004);
        sendByte(8'hF0);
        sendByte(8'h1C); checkEvent("brkUnk", 0, 0, 0, 5'd28, 29'h1000_0004);

        // clearAll beats a same-cycle break and returns the parser to IDLE
        sendByte(8'h0D); checkEvent("make0D", 1, 0, 0, 5'd14, 29'h1000_4004);
        sendByte(8'hF0);
        @(negedge clk);
        bus.recievedData    = 8'h0D;
        bus.recievedNewData = 1'b1;
        bus.clearAll        = 1'b1;
        @(posedge clk);
        #1;
        bus.recievedNewData = 1'b0;
        bus.clearAll        = 1'b0;
        checkEvent("clearAll", 0, 0, 0, 5'd14, 29'h0);
        sendByte(8'h0D); checkEvent("postClear0D", 1, 0, 0, 5'd14, 29'h0000_4000);

        // Prefix timeout: after exactly PREFIX_TIMEOUT idle cycles the next byte is a make
        sendByte(8'hF0);
        repeat (100) @(posedge clk);
        #1;
        sendByte(8'h29); checkEvent("timeoutMake", 1, 0, 0, 5'd28, 29'h1000_4000);
        sendByte(8'hF0);
        repeat (50) @(posedge clk);
        #1;
        sendByte(8'h29); checkEvent("noTimeoutBrk", 0, 1, 0, 5'd28, 29'h0000_4000);

        // Asynchronous reset mid-sequence clears outputs without a clock edge
        sendByte(8'hF0);
        #2;
        resetn = 1'b0;
        #1;
        checkEvent("asyncRst", 0, 0, 0, 5'd0, 29'h0);
        @(negedge clk);
        resetn = 1'b1;
        sendByte(8'h29); checkEvent("postRst29", 1, 0, 0, 5'd28, 29'h1000_0000);
        tick();          checkEvent("postRst29_end", 0, 0, 0, 5'd28, 29'h1000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
